qpsk_symbol_sequencer: RTL and testbench
========================================

# qpsk_symbol_sequencer

- Buffers 2-bit QPSK symbols from an upstream valid/ready source.
- Sequences them onto a single 16-entry, 9-bit symbol waveform table, emitting one DAC sample per clock and 16 samples per symbol.
- Each symbol's waveform is produced by rotating the table address, so one table serves all four symbols.
- Sits between the bit mapper and the DAC interface; replaces the free-running per-symbol table generators.

## Interface

Parameters:
- FIFO_DEPTH, 4, symbol FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  sample clock, rising edge
- rst  input  1  synchronous, active-high reset
- sym_data  input  2  symbol {b1,b0}; b1: cos sign (0 = −cos, 1 = +cos); b0: sin sign (0 = −sin, 1 = +sin)
- sym_valid  input  1  sym_data is valid
- sym_ready  output  1  FIFO can accept; a transfer occurs when sym_valid && sym_ready at a clock edge
- sample_out  output  9  unsigned DAC sample, registered
- sample_valid  output  1  sample_out is a modulated sample, not the idle level
- sym_start  output  1  one-cycle pulse aligned with sample 0 of every symbol
- burst_end  output  1  one-cycle pulse on the first idle sample after a symbol, when the FIFO was empty

## Operation

- Base table B[0..15] = 41,87,141,195,241,272,282,272,241,195,141,87,41,10,0,10. This is the waveform for symbol 01 (−cos+sin).
- Rotation offset d(sym): 01→0, 11→4, 10→8, 00→12.
- Sample n of symbol s = B[(n + d(s)) mod 16]. The index is 4-bit, so wrap-around is natural.
- IDLE_LEVEL = 141 (mid-scale).
- FIFO:
  - sym_ready = !full && !rst.
  - full is based on the registered count, so no push is allowed when full, even if a pop occurs the same cycle.
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
  - Strict FIFO order.
- State machine IDLE / RUN, with a 4-bit phase counter and a cur_sym register.
  - IDLE, FIFO empty: sample_out←141, sample_valid←0. Stay in IDLE.
  - IDLE, FIFO non-empty: pop the head into cur_sym; sample_out←B[d(head)]; sample_valid←1; sym_start←1; phase←1; go to RUN.
  - RUN, phase≠0: sample_out←B[(phase+d(cur_sym)) mod 16]; phase←phase+1, wrapping 15→0.
  - RUN, phase==0 (previous symbol's 16 samples are complete), FIFO non-empty: pop and emit sample 0 of the new symbol exactly as in IDLE. No gap sample is inserted.
  - RUN, phase==0, FIFO empty: sample_out←141; sample_valid←0; burst_end←1; go to IDLE.
- Reset, including mid-symbol: state←IDLE, phase←0, FIFO flushed (queued symbols discarded), sample_out←141, sample_valid←0, sym_start←0, burst_end←0.

## Timing

- All outputs are registered except sym_ready, which is combinational from the FIFO count and rst.
- Latency from IDLE: a symbol accepted at edge E0 is popped at E1, and its sample 0 is visible after E1. Samples 1..15 follow after E2..E16.
- Back-to-back symbols: the next symbol's sample 0 is visible after E17. sample_valid stays high continuously.
- One sample per clock. A symbol occupies exactly 16 cycles.
- sym_start is high for exactly one cycle per symbol. burst_end is high for one cycle per burst.

## Structure

- Package qpsk_pkg contains:
  - IDLE_LEVEL
  - base table B as a localparam array
  - sample width (9) and symbol width (2)
  - function rot_offset(sym) returning d
  - state enum {IDLE, RUN}
- Sub-module qpsk_sym_fifo: parameterized synchronous FIFO with push/pop/full/empty/count, reset by rst.
- The table lookup is inline in the sequencer.

## Test plan

- Reset: hold rst 3 cycles, then release. Required: sample_out=141, sample_valid=0, sym_start=0, burst_end=0; sym_ready=0 while rst is high and 1 after release.
- Single symbol 01 from IDLE, accepted at E0. Required: samples 41,87,141,195,241,272,282,272,241,195,141,87,41,10,0,10 visible after E1..E16; sym_start only with 41; after E17 sample_out=141, sample_valid=0, burst_end=1 for that cycle only.
- Symbols 11 then 00, back-to-back. Required 32 samples with no gap:
  - 11: 241,272,282,272,241,195,141,87,41,10,0,10,41,87,141,195
  - 00: 41,10,0,10,41,87,141,195,241,272,282,272,241,195,141,87
  - sym_start at sample 0 and sample 16.
- Symbol 10 alone. Required: 241,195,141,87,41,10,0,10,41,87,141,195,241,272,282,272.
- Back-pressure: sym_valid held high with 6 symbols from IDLE (pushes E0..E4, first pop at E1). Required: count=4 and sym_ready=0 after E4; sym_ready returns to 1 only after the pop at E17; all 6 symbols emitted in order with no gaps.
- Reset mid-operation: assert rst during phase 7 of a symbol with 2 symbols queued. Required: the following cycle shows 141, sample_valid=0, FIFO empty; no further modulated samples until new symbols are pushed.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared constants, waveform table and types for the QPSK symbol sequencer.
package qpsk_pkg;

    localparam int SAMPLE_W = 9;
    localparam int SYM_W    = 2;

    localparam logic [SAMPLE_W-1:0] IDLE_LEVEL = 9'd141;

    // One period of the waveform for symbol 01 (-cos +sin); the other three
    // symbols are the same period started at a different index.
    localparam logic [SAMPLE_W-1:0] BASE_TABLE [16] = '{
        9'd41,  9'd87,  9'd141, 9'd195, 9'd241, 9'd272, 9'd282, 9'd272,
        9'd241, 9'd195, 9'd141, 9'd87,  9'd41,  9'd10,  9'd0,   9'd10
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Table start index for a symbol: a quarter-period shift per step.
    function automatic logic [3:0] rot_offset(input logic [SYM_W-1:0] sym);
        logic [3:0] d;
        case (sym)
            2'b01:   d = 4'd0;
            2'b11:   d = 4'd4;
            2'b10:   d = 4'd8;
            default: d = 4'd12;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/qpsk_sym_fifo.sv
// Synchronous symbol FIFO; full/empty come from the registered count.
module qpsk_sym_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push is refused whenever the registered count says full, even if a
    // pop happens on the same edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array: data only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; reset flushes all queued symbols.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/qpsk_symbol_sequencer.sv
// Buffers QPSK symbols and plays each one as 16 samples of a rotated
// sine-table lookup, one DAC sample per clock.
module qpsk_symbol_sequencer
    import qpsk_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SYM_W-1:0]    sym_data,
    input  logic                sym_valid,
    output logic                sym_ready,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                sym_start,
    output logic                burst_end
);

    localparam logic [3:0] PHASE_ONE = 4'd1;

    logic [SYM_W-1:0]          fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      fifo_push;
    logic                      fifo_pop;

    state_t                    state_q, state_d;
    logic [3:0]                phase_q, phase_d;
    logic [SYM_W-1:0]          cur_sym_q, cur_sym_d;
    logic [SAMPLE_W-1:0]       sample_q, sample_d;
    logic                      sample_valid_q, sample_valid_d;
    logic                      sym_start_q, sym_start_d;
    logic                      burst_end_q, burst_end_d;
    logic [3:0]                run_idx;
    logic [3:0]                head_idx;

    assign sym_ready = !fifo_full && !rst;
    assign fifo_push = sym_valid && sym_ready;

    qpsk_sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SYM_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (sym_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // 4-bit indices wrap modulo 16 on their own.
    assign run_idx  = phase_q + rot_offset(cur_sym_q);
    assign head_idx = rot_offset(fifo_head);

    // Next-state and next-output logic; phase==0 in RUN marks a symbol boundary.
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        cur_sym_d      = cur_sym_q;
        sample_d       = IDLE_LEVEL;
        sample_valid_d = 1'b0;
        sym_start_d    = 1'b0;
        burst_end_d    = 1'b0;
        fifo_pop       = 1'b0;

        if ((state_q == RUN) && (phase_q != 4'd0)) begin
            sample_d       = BASE_TABLE[run_idx];
            sample_valid_d = 1'b1;
            phase_d        = phase_q + PHASE_ONE;
        end else if (!fifo_empty) begin
            // Start a new symbol straight from the FIFO head, with no gap sample.
            fifo_pop       = 1'b1;
            cur_sym_d      = fifo_head;
            sample_d       = BASE_TABLE[head_idx];
            sample_valid_d = 1'b1;
            sym_start_d    = 1'b1;
            phase_d        = PHASE_ONE;
            state_d        = RUN;
        end else if (state_q == RUN) begin
            // Last symbol finished and nothing is waiting: close the burst.
            burst_end_d    = 1'b1;
            state_d        = IDLE;
        end
    end

    // Control state and registered outputs; reset returns to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            phase_q        <= 4'd0;
            sample_q       <= IDLE_LEVEL;
            sample_valid_q <= 1'b0;
            sym_start_q    <= 1'b0;
            burst_end_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            sym_start_q    <= sym_start_d;
            burst_end_q    <= burst_end_d;
        end
    end

    // Current symbol holder; only meaningful while in RUN, so it is not reset.
    always_ff @(posedge clk) begin
        cur_sym_q <= cur_sym_d;
    end

    assign sample_out   = sample_q;
    assign sample_valid = sample_valid_q;
    assign sym_start    = sym_start_q;
    assign burst_end    = burst_end_q;

endmodule

// File: tb/tb_qpsk_symbol_sequencer.sv
// Directed bench for qpsk_symbol_sequencer with a queue of expected samples.
module tb_qpsk_symbol_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sym_data = 2'b00;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic [8:0] sample_out;
    logic       sample_valid;
    logic       sym_start;
    logic       burst_end;

    qpsk_symbol_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sym_data     (sym_data),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sym_start    (sym_start),
        .burst_end    (burst_end)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sample;
        bit start;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   prev_vld = 1'b0;

    localparam int TB_TABLE [16] = '{41, 87, 141, 195, 241, 272, 282, 272,
                                     241, 195, 141, 87, 41, 10, 0, 10};

    function automatic int tb_rot(input logic [1:0] s);
        case (s)
            2'b01:   return 0;
            2'b11:   return 4;
            2'b10:   return 8;
            default: return 12;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [1:0] s);
        for (int n = 0; n < 16; n++) begin
            exp_q.push_back('{sample: TB_TABLE[(n + tb_rot(s)) % 16], start: (n == 0)});
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [1:0] s, input bit keep, output int acc);
        int n;
        n = 0;
        sym_data  = s;
        sym_valid = 1'b1;
        while (!sym_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!sym_ready) begin
            check("send_timeout", 32'(n), 0);
            sym_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        acc = cyc;
        push_exp(s);
        @(negedge clk);
        if (!keep) sym_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sample_valid) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    // Output monitor: every valid sample must be the next expected one.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sample_valid) begin
                check("sample_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sample", 32'(sample_out), e.sample);
                    check("sym_start", 32'(sym_start), 32'(e.start));
                end
                check("burst_end_in_burst", 32'(burst_end), 0);
            end else begin
                check("idle_level", 32'(sample_out), 141);
                check("idle_sym_start", 32'(sym_start), 0);
                check("burst_end", 32'(burst_end), 32'(prev_vld));
                if (prev_vld) check("no_gap", 32'(exp_q.size()), 0);
            end
            prev_vld = sample_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, a4, a5, a6;
        int seen;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(sym_ready), 0);
            check("rst_sample", 32'(sample_out), 141);
            check("rst_valid", 32'(sample_valid), 0);
            check("rst_sym_start", 32'(sym_start), 0);
            check("rst_burst_end", 32'(burst_end), 0);
        end
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(sym_ready), 1);
        prev_vld = 1'b0;
        mon_en = 1'b1;

        // Single symbol 01 from idle.
        send(2'b01, 1'b0, a1);
        wait_drain("single01_drain");

        // 11 then 00 back-to-back.
        send(2'b11, 1'b1, a1);
        send(2'b00, 1'b0, a2);
        check("b2b_accept_gap", 32'(a2 - a1), 1);
        wait_drain("b2b_drain");

        // Symbol 10 alone.
        send(2'b10, 1'b0, a1);
        wait_drain("sym10_drain");

        // Back-pressure with six symbols offered continuously.
        send(2'b01, 1'b1, a1);
        send(2'b11, 1'b1, a2);
        send(2'b00, 1'b1, a3);
        send(2'b10, 1'b1, a4);
        send(2'b01, 1'b1, a5);
        check("bp_fill_edges", 32'(a5 - a1), 4);
        check("bp_ready_full", 32'(sym_ready), 0);
        check("bp_count_full", 32'(dut.u_fifo.count_o), 4);
        send(2'b11, 1'b0, a6);
        check("bp_sixth_accept", 32'(a6 - a1), 18);
        wait_drain("bp_drain");

        // Reset during phase 7 with two symbols still queued.
        send(2'b10, 1'b1, a1);
        send(2'b11, 1'b1, a2);
        send(2'b00, 1'b0, a3);
        repeat (5) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("midrst_queued", 32'(dut.u_fifo.count_o), 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sample", 32'(sample_out), 141);
        check("midrst_valid", 32'(sample_valid), 0);
        check("midrst_sym_start", 32'(sym_start), 0);
        check("midrst_burst_end", 32'(burst_end), 0);
        check("midrst_ready", 32'(sym_ready), 0);
        check("midrst_fifo_empty", 32'(dut.u_fifo.count_o), 0);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_ready_release", 32'(sym_ready), 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sample_valid) seen++;
        end
        check("midrst_stays_idle", 32'(seen), 0);
        prev_vld = 1'b0;
        mon_en = 1'b1;

        // Recovery after the mid-operation reset.
        send(2'b00, 1'b0, a4);
        wait_drain("recover_drain");

        check("final_queue_empty", 32'(exp_q.size()), 0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
